// File: rtl/decode_stage.sv
// Buffered decode stage for the 8-bit NAND CPU: decodes fetched bytes into bundles,
// queues them in a small FIFO and gates intake with a run/halt/interrupt state machine.
module decode_stage #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_instr,
  input  logic [PC_W-1:0]              in_pc,
  input  logic                         flush,
  input  logic                         resume,
  input  logic                         int_ack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic                         out_use_ra,
  output logic                         out_use_rt,
  output logic                         out_use_rw,
  output logic [3:0]                   out_rt_addr,
  output logic [3:0]                   out_rw_addr,
  output logic                         out_read_ps,
  output logic                         out_write_ps,
  output logic                         out_use_immdt,
  output logic [3:0]                   out_immdt,
  output logic [1:0]                   out_shift,
  output logic                         out_jump,
  output logic                         out_branch,
  output logic                         out_mem_read,
  output logic                         out_mem_write,
  output logic                         out_interrupt,
  output logic                         out_halt,
  output logic [ALU_OP_W-1:0]          out_alu_op,
  output logic [$clog2(DEPTH+1)-1:0]   out_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] CntFull  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PtrLast  = PTR_W'(DEPTH - 1);

  localparam logic [ALU_OP_W-1:0] AluNop  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] AluClr  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] AluCp   = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] AluNand = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] AluLs   = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] AluRs   = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] AluEq   = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] AluNe   = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] AluLi   = ALU_OP_W'(8);

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic                use_ra;
    logic                use_rt;
    logic                use_rw;
    logic [3:0]          rt_addr;
    logic [3:0]          rw_addr;
    logic                read_ps;
    logic                write_ps;
    logic                use_immdt;
    logic [3:0]          immdt;
    logic [1:0]          shift;
    logic                jump;
    logic                branch;
    logic                mem_read;
    logic                mem_write;
    logic                interrupt;
    logic                halt;
    logic [ALU_OP_W-1:0] alu_op;
  } bundle_t;

  typedef enum logic [1:0] {StRun, StHalted, StIntWait} state_e;

  state_e           state_q, state_d;
  bundle_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  bundle_t          dec;
  bundle_t          head;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Decode of the incoming byte; immdt/shift/rt_addr are raw instruction fields.
  always_comb begin
    dec           = '0;
    dec.pc        = in_pc;
    dec.rt_addr   = in_instr[3:0];
    dec.immdt     = in_instr[3:0];
    dec.shift     = in_instr[5:4];
    dec.alu_op    = AluNop;
    casez (in_instr[7:4])
      4'b0000: begin
        if (in_instr[3:0] == 4'h0) begin
          dec.use_rw = 1'b1;
          dec.alu_op = AluClr;
        end else begin
          dec.use_ra  = 1'b1;
          dec.use_rw  = 1'b1;
          dec.rw_addr = in_instr[3:0];
          dec.alu_op  = AluCp;
        end
      end
      4'b0001, 4'b0010, 4'b0011: begin
        dec.use_ra = 1'b1;
        dec.use_rt = 1'b1;
        dec.use_rw = 1'b1;
        dec.alu_op = (in_instr[5:4] == 2'b01) ? AluNand :
                     (in_instr[5:4] == 2'b10) ? AluLs : AluRs;
      end
      4'b0100, 4'b0101: begin
        dec.use_ra   = 1'b1;
        dec.use_rt   = 1'b1;
        dec.write_ps = 1'b1;
        dec.alu_op   = in_instr[4] ? AluNe : AluEq;
      end
      4'b0110: begin
        dec.use_rt  = 1'b1;
        dec.read_ps = 1'b1;
        dec.branch  = 1'b1;
      end
      4'b0111: begin
        dec.use_rt  = 1'b1;
        dec.use_rw  = 1'b1;
        dec.rw_addr = in_instr[3:0];
        dec.jump    = 1'b1;
      end
      4'b10??: begin
        dec.use_ra    = 1'b1;
        dec.use_rw    = 1'b1;
        dec.use_immdt = 1'b1;
        dec.alu_op    = AluLi;
      end
      4'b1100: begin
        dec.use_rt   = 1'b1;
        dec.use_rw   = 1'b1;
        dec.mem_read = 1'b1;
      end
      4'b1101: begin
        dec.use_ra    = 1'b1;
        dec.use_rt    = 1'b1;
        dec.mem_write = 1'b1;
      end
      4'b1110: begin
        dec.use_immdt = 1'b1;
        dec.interrupt = 1'b1;
      end
      default: begin
        dec.use_immdt = 1'b1;
        dec.halt      = 1'b1;
      end
    endcase
  end

  assign in_ready  = (state_q == StRun) && (count_q < CntFull);
  assign out_valid = (count_q != '0);
  // Flush overrides both sides of the FIFO in the same cycle.
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop) count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (push && dec.halt) state_d = StHalted;
          else if (push && dec.interrupt) state_d = StIntWait;
        end
        StHalted:  if (resume)  state_d = StRun;
        StIntWait: if (int_ack) state_d = StRun;
        default:   state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= dec;
    end
  end

  // Bundle outputs read as zero whenever the FIFO is empty.
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc        = head.pc;
  assign out_use_ra    = head.use_ra;
  assign out_use_rt    = head.use_rt;
  assign out_use_rw    = head.use_rw;
  assign out_rt_addr   = head.rt_addr;
  assign out_rw_addr   = head.rw_addr;
  assign out_read_ps   = head.read_ps;
  assign out_write_ps  = head.write_ps;
  assign out_use_immdt = head.use_immdt;
  assign out_immdt     = head.immdt;
  assign out_shift     = head.shift;
  assign out_jump      = head.jump;
  assign out_branch    = head.branch;
  assign out_mem_read  = head.mem_read;
  assign out_mem_write = head.mem_write;
  assign out_interrupt = head.interrupt;
  assign out_halt      = head.halt;
  assign out_alu_op    = head.alu_op;
  assign out_count     = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and scoreboarded checks of decode_stage: decode table, FIFO handshake,
// halt/interrupt gating, flush and async reset.
module tb_decode_stage;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_instr = 8'h00;
  logic [7:0] in_pc = 8'h00;
  logic       flush = 1'b0;
  logic       resume = 1'b0;
  logic       int_ack = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_pc;
  logic       out_use_ra, out_use_rt, out_use_rw;
  logic [3:0] out_rt_addr, out_rw_addr;
  logic       out_read_ps, out_write_ps, out_use_immdt;
  logic [3:0] out_immdt;
  logic [1:0] out_shift;
  logic       out_jump, out_branch, out_mem_read, out_mem_write, out_interrupt, out_halt;
  logic [3:0] out_alu_op;
  logic [1:0] out_count;

  int n_checks = 0;
  int n_errors = 0;

  decode_stage #(.DEPTH(DEPTH), .PC_W(8), .ALU_OP_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .resume(resume), .int_ack(int_ack), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_use_ra(out_use_ra), .out_use_rt(out_use_rt),
    .out_use_rw(out_use_rw), .out_rt_addr(out_rt_addr), .out_rw_addr(out_rw_addr),
    .out_read_ps(out_read_ps), .out_write_ps(out_write_ps), .out_use_immdt(out_use_immdt),
    .out_immdt(out_immdt), .out_shift(out_shift), .out_jump(out_jump),
    .out_branch(out_branch), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_interrupt(out_interrupt), .out_halt(out_halt), .out_alu_op(out_alu_op),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flag/address fields of the head bundle, excluding pc, immdt and shift.
  function automatic logic [31:0] obs();
    return {8'h00, out_use_ra, out_use_rt, out_use_rw, out_rt_addr, out_rw_addr, out_read_ps,
            out_write_ps, out_use_immdt, out_jump, out_branch, out_mem_read, out_mem_write,
            out_interrupt, out_halt, out_alu_op};
  endfunction

  function automatic logic [31:0] mk(input int ra, input int rt, input int rw, input int rta,
                                     input int rwa, input int rps, input int wps, input int ui,
                                     input int j, input int b, input int mr, input int mw,
                                     input int it, input int h, input int op);
    return {8'h00, ra[0], rt[0], rw[0], rta[3:0], rwa[3:0], rps[0], wps[0], ui[0], j[0], b[0],
            mr[0], mw[0], it[0], h[0], op[3:0]};
  endfunction

  logic [7:0]  stim [12];
  logic [31:0] expv [12];

  initial begin
    logic [7:0]  q_instr [$];
    logic [7:0]  q_pc [$];
    logic [7:0]  cur_instr;
    logic [31:0] prev, snap;
    logic        stalled, nv, push, pop;
    int          sent, cyc;

    stim[0]  = 8'h00; expv[0]  = mk(0,0,1, 0,0, 0,0,0, 0,0,0,0,0,0, 1);
    stim[1]  = 8'h05; expv[1]  = mk(1,0,1, 5,5, 0,0,0, 0,0,0,0,0,0, 2);
    stim[2]  = 8'h1A; expv[2]  = mk(1,1,1, 10,0, 0,0,0, 0,0,0,0,0,0, 3);
    stim[3]  = 8'h9B; expv[3]  = mk(1,0,1, 11,0, 0,0,1, 0,0,0,0,0,0, 8);
    stim[4]  = 8'hC3; expv[4]  = mk(0,1,1, 3,0, 0,0,0, 0,0,1,0,0,0, 0);
    stim[5]  = 8'hD4; expv[5]  = mk(1,1,0, 4,0, 0,0,0, 0,0,0,1,0,0, 0);
    stim[6]  = 8'h67; expv[6]  = mk(0,1,0, 7,0, 1,0,0, 0,1,0,0,0,0, 0);
    stim[7]  = 8'h72; expv[7]  = mk(0,1,1, 2,2, 0,0,0, 1,0,0,0,0,0, 0);
    stim[8]  = 8'h21; expv[8]  = mk(1,1,1, 1,0, 0,0,0, 0,0,0,0,0,0, 4);
    stim[9]  = 8'h3F; expv[9]  = mk(1,1,1, 15,0, 0,0,0, 0,0,0,0,0,0, 5);
    stim[10] = 8'h45; expv[10] = mk(1,1,0, 5,0, 0,1,0, 0,0,0,0,0,0, 6);
    stim[11] = 8'h5C; expv[11] = mk(1,1,0, 12,0, 0,1,0, 0,0,0,0,0,0, 7);

    // Reset state
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_bundle", obs(), 0);
    check("rst_pc", out_pc, 0);
    step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Reset mid-stream with two entries queued
    in_valid = 1'b1; in_instr = 8'h11; in_pc = 8'h01;
    step();
    in_instr = 8'h12; in_pc = 8'h02;
    step();
    in_valid = 1'b0;
    check("mid_count_pre", out_count, 2);
    #1 rst = 1'b1;
    #1;
    check("mid_count_async", out_count, 0);
    check("mid_valid_async", out_valid, 0);
    rst = 1'b0;
    #1;
    check("mid_in_ready", in_ready, 1);
    check("mid_valid", out_valid, 0);
    step();

    // Stream decode with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_instr = stim[i]; in_pc = 8'h40 + 8'(i);
      step();
      check($sformatf("dec_%02h", stim[i]), obs(), expv[i]);
      check($sformatf("pc_%02h", stim[i]), out_pc, 32'h40 + i);
      check($sformatf("vld_%02h", stim[i]), out_valid, 1);
      check($sformatf("cnt_%02h", stim[i]), out_count, 1);
      if (stim[i] == 8'h9B) begin
        check("li_shift", out_shift, 1);
        check("li_immdt", out_immdt, 4'hB);
      end
    end
    in_valid = 1'b0;
    step();
    check("stream_drain", out_count, 0);

    // Fill with out_ready low; third instruction must be held off
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 8'h11; in_pc = 8'h20;
    step();
    check("fill1_cnt", out_count, 1);
    check("fill1_rdy", in_ready, 1);
    in_instr = 8'h12; in_pc = 8'h21;
    step();
    check("fill2_cnt", out_count, 2);
    check("fill2_rdy", in_ready, 0);
    in_instr = 8'h13; in_pc = 8'h22;
    step();
    check("fill3_cnt", out_count, 2);
    check("fill3_head", out_pc, 8'h20);
    out_ready = 1'b1;
    step();
    check("drain1_head", out_pc, 8'h21);
    check("drain1_cnt", out_count, 1);
    step();
    check("pp_head", out_pc, 8'h22);
    check("pp_cnt", out_count, 1);
    in_valid = 1'b0;
    step();
    check("fill_empty", out_count, 0);

    // HLT: intake stops, int_ack ignored, resume releases
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 8'hF0; in_pc = 8'h30;
    step();
    in_valid = 1'b0;
    check("hlt_rdy", in_ready, 0);
    check("hlt_bundle", obs(), mk(0,0,0, 0,0, 0,0,1, 0,0,0,0,0,1, 0));
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    check("hlt_ack_ignored", in_ready, 0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("hlt_resume", in_ready, 1);
    out_ready = 1'b1;
    step();
    check("hlt_pop", out_count, 0);

    // INT then flush with one entry queued
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 8'hE1; in_pc = 8'h31;
    step();
    check("int_rdy", in_ready, 0);
    check("int_bundle", obs(), mk(0,0,0, 1,0, 0,0,1, 0,0,0,0,1,0, 0));
    in_valid = 1'b0; resume = 1'b1;
    step();
    resume = 1'b0;
    check("int_resume_ignored", in_ready, 0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 8'h11; in_pc = 8'h32;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_cnt", out_count, 0);
    check("flush_vld", out_valid, 0);
    check("flush_rdy", in_ready, 1);

    // Flush in RUN beats a simultaneous push and pop
    in_valid = 1'b1; in_instr = 8'h05; in_pc = 8'h33;
    step();
    check("flush2_pre", out_count, 1);
    flush = 1'b1; out_ready = 1'b1; in_instr = 8'h06; in_pc = 8'h34;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush2_cnt", out_count, 0);
    check("flush2_bundle", obs(), 0);

    // Random traffic against a scoreboard
    sent = 0; cyc = 0; stalled = 1'b0; prev = '0;
    cur_instr = 8'($urandom_range(0, 223));
    while ((sent < 100 || q_pc.size() != 0) && cyc < 3000) begin
      check("rnd_cnt", out_count, q_pc.size());
      check("rnd_vld", out_valid, q_pc.size() != 0);
      check("rnd_rdy", in_ready, q_pc.size() < DEPTH);
      if (q_pc.size() != 0) begin
        check("rnd_pc", out_pc, q_pc[0]);
        check("rnd_rt", out_rt_addr, q_instr[0][3:0]);
      end
      snap = obs();
      snap[31:24] = out_pc;
      if (stalled) check("rnd_stable", snap, prev);
      nv = (sent < 100) && ($urandom_range(0, 3) != 0);
      in_valid = nv; in_instr = cur_instr; in_pc = 8'(sent);
      out_ready = 1'($urandom_range(0, 1));
      push = nv && (q_pc.size() < DEPTH);
      pop = out_ready && (q_pc.size() != 0);
      stalled = (q_pc.size() != 0) && !out_ready;
      prev = snap;
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_instr.pop_front());
      end
      if (push) begin
        q_pc.push_back(8'(sent));
        q_instr.push_back(cur_instr);
        sent++;
        cur_instr = 8'($urandom_range(0, 223));
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rnd_sent", sent, 100);
    check("rnd_drained", q_pc.size(), 0);
    check("rnd_final_cnt", out_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
